// File: rtl/asi_pkg.sv
// Shared AXI widths, burst types and AMI read-master types.
// Widths are fixed here so every master/slave block agrees on the bus shape.
package asi_pkg;

  localparam int AXI_IW     = 4;
  localparam int AXI_AW     = 32;
  localparam int AXI_DW     = 32;
  localparam int AXI_LW     = 8;
  localparam int AXI_SW     = 3;
  localparam int AXI_BURSTW = 2;
  localparam int AXI_RRESPW = 2;

  typedef enum logic [AXI_BURSTW-1:0] {
    BT_FIXED = 2'd0,
    BT_INCR  = 2'd1,
    BT_WRAP  = 2'd2
  } bt_t;

  typedef enum logic [2:0] {
    AMI_ERR_NONE   = 3'd0,
    AMI_ERR_RLAST  = 3'd1,
    AMI_ERR_RID    = 3'd2,
    AMI_ERR_UNEXP  = 3'd3,
    AMI_ERR_CMDLEN = 3'd4
  } ami_err_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_LW-1:0] len;
  } trk_t;

  typedef struct packed {
    logic [AXI_IW-1:0]     id;
    logic [AXI_DW-1:0]     data;
    logic [AXI_RRESPW-1:0] resp;
    logic                  last;
  } rbeat_t;

endpackage

// File: rtl/sfifo.sv
// Synchronous first-word-fall-through FIFO, depth 2**AW; head visible same cycle as !empty.
// Push while full and pop while empty are ignored; FPGA_IP!=0 drops the storage reset for RAM inference.
module sfifo #(
  parameter int AW      = 2,
  parameter int DW      = 8,
  parameter int FPGA_IP = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  output logic          full,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  // cnt tops out at DEPTH, so its MSB alone marks full
  assign full    = cnt[AW];
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  if (FPGA_IP != 0) begin : g_ram_nrst
    always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= push_dat;
    end
  end else begin : g_ram_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
        mem[wp] <= push_dat;
      end
    end
  end

endmodule

// File: rtl/ami_r.sv
// AXI read master: user command -> registered AR, R beats checked against a tracking queue into a FWFT buffer.
// Commands are admitted only when buffer space is reserved, so RREADY stays high in legal use.
module ami_r
  import asi_pkg::*;
#(
  parameter int MST_OD  = 4,
  parameter int MST_RD  = 64,
  parameter int FPGA_IP = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  output logic [AXI_IW-1:0]       ARID,
  output logic [AXI_AW-1:0]       ARADDR,
  output logic [AXI_LW-1:0]       ARLEN,
  output logic [AXI_SW-1:0]       ARSIZE,
  output logic [AXI_BURSTW-1:0]   ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [AXI_IW-1:0]       RID,
  input  logic [AXI_DW-1:0]       RDATA,
  input  logic [AXI_RRESPW-1:0]   RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic [AXI_IW-1:0]       u_cmd_id,
  input  logic [AXI_AW-1:0]       u_cmd_addr,
  input  logic [AXI_LW-1:0]       u_cmd_len,
  input  logic [AXI_SW-1:0]       u_cmd_size,
  input  logic [AXI_BURSTW-1:0]   u_cmd_burst,
  input  logic                    u_cmd_valid,
  output logic                    u_cmd_ready,
  output logic [AXI_IW-1:0]       u_rid,
  output logic [AXI_DW-1:0]       u_rdata,
  output logic [AXI_RRESPW-1:0]   u_rresp,
  output logic                    u_rlast,
  output logic                    u_rvalid,
  input  logic                    u_rready,
  output logic [$clog2(MST_OD):0] u_os_cnt,
  output logic                    u_err,
  output logic [2:0]              u_err_code,
  input  logic                    u_err_clr
);

  localparam int OD_AW = $clog2(MST_OD);
  localparam int RD_AW = $clog2(MST_RD);
  localparam int RSV_W = RD_AW + 1;

  logic             run;
  logic [RSV_W-1:0] resv;
  logic [AXI_LW-1:0] beat;
  ami_err_t         err_q, err_new;
  trk_t             trk_in, trk_head;
  rbeat_t           rbuf_in, rbuf_head;
  logic             trk_full, trk_empty, rbuf_full, rbuf_empty;
  logic             cmd_big, cmd_fit, cmd_acc, cmd_iss;
  logic             r_hs, r_ok, r_end, u_pop;

  // Oversized commands are always admissible: they are swallowed and flagged, never issued
  always_comb begin
    cmd_big     = (32'(u_cmd_len) + 32'd1) > 32'(MST_RD);
    cmd_fit     = (32'(resv) + 32'(u_cmd_len) + 32'd1) <= 32'(MST_RD);
    u_cmd_ready = run & ~ARVALID &
                  (cmd_big | ((32'(u_os_cnt) < 32'(MST_OD)) & cmd_fit & ~trk_full));
  end

  assign cmd_acc = u_cmd_valid & u_cmd_ready;
  assign cmd_iss = cmd_acc & ~cmd_big;
  assign r_hs    = RVALID & RREADY;
  assign r_ok    = r_hs & ~trk_empty;
  assign r_end   = r_ok & RLAST;
  assign u_pop   = u_rvalid & u_rready;
  assign RREADY  = ~rbuf_full;

  // Priority when several checks trip on one beat: UNEXP, RLAST, RID, then CMDLEN
  always_comb begin
    err_new = AMI_ERR_NONE;
    if (r_hs && trk_empty)                               err_new = AMI_ERR_UNEXP;
    else if (r_ok && (RLAST != (beat == trk_head.len))) err_new = AMI_ERR_RLAST;
    else if (r_ok && (RID != trk_head.id))              err_new = AMI_ERR_RID;
    else if (cmd_acc && cmd_big)                        err_new = AMI_ERR_CMDLEN;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      run      <= 1'b0;
      ARVALID  <= 1'b0;
      ARID     <= '0;
      ARADDR   <= '0;
      ARLEN    <= '0;
      ARSIZE   <= '0;
      ARBURST  <= '0;
      resv     <= '0;
      u_os_cnt <= '0;
      beat     <= '0;
      err_q    <= AMI_ERR_NONE;
    end else begin
      run <= 1'b1;
      if (cmd_iss) begin
        ARVALID <= 1'b1;
        ARID    <= u_cmd_id;
        ARADDR  <= u_cmd_addr;
        ARLEN   <= u_cmd_len;
        ARSIZE  <= u_cmd_size;
        ARBURST <= u_cmd_burst;
      end else if (ARREADY) begin
        ARVALID <= 1'b0;
      end
      resv <= RSV_W'(32'(resv) + (cmd_iss ? 32'(u_cmd_len) + 32'd1 : 32'd0)
                     - (u_pop ? 32'd1 : 32'd0));
      if (cmd_iss && !r_end)      u_os_cnt <= u_os_cnt + 1'b1;
      else if (!cmd_iss && r_end) u_os_cnt <= u_os_cnt - 1'b1;
      if (r_ok) beat <= RLAST ? '0 : beat + 1'b1;
      // A clear in the same cycle as a new error yields to the new error
      if (err_new != AMI_ERR_NONE && (err_q == AMI_ERR_NONE || u_err_clr)) err_q <= err_new;
      else if (u_err_clr)                                                  err_q <= AMI_ERR_NONE;
    end
  end

  assign u_err      = (err_q != AMI_ERR_NONE);
  assign u_err_code = err_q;

  assign trk_in  = '{id: u_cmd_id, len: u_cmd_len};
  assign rbuf_in = '{id: RID, data: RDATA, resp: RRESP, last: RLAST};

  sfifo #(.AW(OD_AW), .DW($bits(trk_t)), .FPGA_IP(FPGA_IP)) u_trk (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .push     (cmd_iss),
    .push_dat (trk_in),
    .full     (trk_full),
    .pop      (r_end),
    .pop_dat  (trk_head),
    .empty    (trk_empty)
  );

  sfifo #(.AW(RD_AW), .DW($bits(rbeat_t)), .FPGA_IP(FPGA_IP)) u_rbuf (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .push     (r_ok),
    .push_dat (rbuf_in),
    .full     (rbuf_full),
    .pop      (u_pop),
    .pop_dat  (rbuf_head),
    .empty    (rbuf_empty)
  );

  assign u_rvalid = ~rbuf_empty;
  assign u_rid    = rbuf_head.id;
  assign u_rdata  = rbuf_head.data;
  assign u_rresp  = rbuf_head.resp;
  assign u_rlast  = rbuf_head.last;

endmodule
